// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage CPU: hazard FSM states, forwarding selects,
// and the register-address width.
package cpu_pkg;

    localparam int unsigned RA_W = 2;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_WB    = 2'd2;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLdStall = 2'd1,
        StHalt    = 2'd2,
        StStep    = 2'd3
    } state_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// EX-stage operand forwarding compare for one source register; EX/MEM wins over MEM/WB,
// and loads are only forwarded once they reach WB.
module hazard_fwd_unit #(
    parameter int unsigned RA_W = cpu_pkg::RA_W
) (
    input  logic [RA_W-1:0] i_src,
    input  logic [RA_W-1:0] i_exmem_wr,
    input  logic            i_exmem_regwrite,
    input  logic            i_exmem_memtoreg,
    input  logic [RA_W-1:0] i_memwb_wr,
    input  logic            i_memwb_regwrite,
    output logic [1:0]      o_fwd
);

    logic w_src_nz;
    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_src_nz    = (i_src != '0);
    assign w_exmem_hit = w_src_nz && i_exmem_regwrite && !i_exmem_memtoreg
                         && (i_exmem_wr == i_src);
    assign w_memwb_hit = w_src_nz && i_memwb_regwrite && (i_memwb_wr == i_src);

    always_comb begin
        o_fwd = cpu_pkg::FWD_RF;
        if (w_exmem_hit) begin
            o_fwd = cpu_pkg::FWD_EXMEM;
        end else if (w_memwb_hit) begin
            o_fwd = cpu_pkg::FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/debug sequencer for the 5-stage CPU: load-use stall, branch flush, halt/single-step,
// EX forwarding selects and saturating stall/flush counters. State changes on the falling edge.
module pipeline_hazard_ctrl #(
    parameter int unsigned RA_W  = cpu_pkg::RA_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RA_W-1:0]  ifid_rs,
    input  logic [RA_W-1:0]  ifid_rt,
    input  logic             ifid_use_rs,
    input  logic             ifid_use_rt,
    input  logic [RA_W-1:0]  idex_rs,
    input  logic [RA_W-1:0]  idex_rt,
    input  logic [RA_W-1:0]  idex_wr,
    input  logic             idex_regwrite,
    input  logic             idex_memtoreg,
    input  logic [RA_W-1:0]  exmem_wr,
    input  logic             exmem_regwrite,
    input  logic             exmem_memtoreg,
    input  logic [RA_W-1:0]  memwb_wr,
    input  logic             memwb_regwrite,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    cpu_pkg::state_e  r_state;
    cpu_pkg::state_e  w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_lu;
    logic             w_stall_inc;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    assign w_lu = idex_regwrite && idex_memtoreg && (idex_wr != '0)
                  && ((ifid_use_rs && (ifid_rs == idex_wr)) || (ifid_use_rt && (ifid_rt == idex_wr)));

    hazard_fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .i_src            (idex_rs),
        .i_exmem_wr       (exmem_wr),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_memtoreg (exmem_memtoreg),
        .i_memwb_wr       (memwb_wr),
        .i_memwb_regwrite (memwb_regwrite),
        .o_fwd            (w_fwd_a)
    );

    hazard_fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .i_src            (idex_rt),
        .i_exmem_wr       (exmem_wr),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_memtoreg (exmem_memtoreg),
        .i_memwb_wr       (memwb_wr),
        .i_memwb_regwrite (memwb_regwrite),
        .o_fwd            (w_fwd_b)
    );

    always_comb begin
        w_state_nxt  = r_state;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        w_stall_inc  = 1'b0;

        unique case (r_state)
            cpu_pkg::StRun, cpu_pkg::StStep: begin
                if (!branch_taken && w_lu) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    w_stall_inc = 1'b1;
                    w_state_nxt = cpu_pkg::StLdStall;
                end else if (r_state == cpu_pkg::StStep) begin
                    w_state_nxt = cpu_pkg::StHalt;
                end else begin
                    // A taken branch defers the halt: the wrong-path slot must be discarded first.
                    w_state_nxt = (halt_req && !branch_taken) ? cpu_pkg::StHalt : cpu_pkg::StRun;
                end
            end
            cpu_pkg::StLdStall: begin
                w_state_nxt = halt_req ? cpu_pkg::StHalt : cpu_pkg::StRun;
            end
            cpu_pkg::StHalt: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                if (step_req) begin
                    w_state_nxt = cpu_pkg::StStep;
                end else if (!halt_req) begin
                    w_state_nxt = cpu_pkg::StRun;
                end
            end
            default: w_state_nxt = cpu_pkg::StRun;
        endcase

        if (branch_taken) begin
            pc_we        = 1'b1;
            ifid_we      = 1'b1;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end

        if (reset) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            w_stall_inc  = 1'b0;
            w_state_nxt  = cpu_pkg::StRun;
        end
    end

    assign halted    = !reset && (r_state == cpu_pkg::StHalt);
    assign fwd_a     = reset ? cpu_pkg::FWD_RF : w_fwd_a;
    assign fwd_b     = reset ? cpu_pkg::FWD_RF : w_fwd_b;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_ff @(negedge clock) begin
        if (reset) begin
            r_state     <= cpu_pkg::StRun;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
